adc_reader: RTL

- SPI reader for the dual-channel 14-bit ADC (LTC1407A-style). It is the capture-side counterpart of the DAC writer.
- On request, it pulses AD_CONV, clocks out 34 SCK cycles, deserialises two signed 14-bit samples from MISO, and presents them with a one-clock ready strobe.
- It sits between the board SPI pins and the synth input/analysis path.

---
 rtl/adc_reader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/adc_reader.sv
// adc_reader: SPI capture for a dual-channel 14-bit ADC (LTC1407A-style).
// Define ADC_PREAMP_EN to preload the preamp gain over SPI after reset.
module adc_reader #(
  parameter int         SCK_DIV  = 2,
  parameter logic [7:0] AMP_GAIN = 8'h11
) (
  input  logic        IN_CLOCK,
  input  logic        IN_RESET_N,
  input  logic        IN_START,
  input  logic        IN_SPI_MISO,
  output logic        OUT_SPI_SCK,
  output logic        OUT_AD_CONV,
  output logic [13:0] OUT_CH0,
  output logic [13:0] OUT_CH1,
  output logic        OUT_SAMPLE_READY,
  output logic        OUT_BUSY,
`ifdef ADC_PREAMP_EN
  output logic        OUT_AMP_CS,
  output logic        OUT_SPI_MOSI,
  output logic        OUT_AMP_SHDN,
`endif
  output logic [2:0]  OUT_STATE
);

  localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CONV     = 3'd1,
    SHIFT    = 3'd2,
    AMP_LOAD = 3'd3
  } state_t;

`ifdef ADC_PREAMP_EN
  localparam state_t RST_ST = AMP_LOAD;
  logic [7:0] amp_sr;
`else
  localparam state_t RST_ST = IDLE;
`endif

  state_t        state, state_nxt;
  logic [DW-1:0] div;
  logic [5:0]    bitcnt;
  logic          sck, ready;
  logic [13:0]   s0, s1, ch0, ch1;
  logic          tick, rise, fall;

  assign tick = (div == DIV_LAST);
  assign rise = tick & ~sck;
  assign fall = tick & sck;

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) state <= RST_ST;
    else             state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (IN_START) state_nxt = CONV;
      CONV:  if (tick && bitcnt == 6'd1) state_nxt = SHIFT;
      SHIFT: if (fall && bitcnt == 6'd34) state_nxt = IDLE;
`ifdef ADC_PREAMP_EN
      AMP_LOAD: if (fall && bitcnt == 6'd8) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // CONV reuses bitcnt to count its two ticks
  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      div    <= '0;
      bitcnt <= '0;
      sck    <= 1'b0;
      ready  <= 1'b0;
      s0     <= '0;
      s1     <= '0;
      ch0    <= '0;
      ch1    <= '0;
`ifdef ADC_PREAMP_EN
      amp_sr <= AMP_GAIN;
`endif
    end else begin
      ready <= 1'b0;
      div   <= tick ? '0 : div + 1'b1;
      unique case (state)
        IDLE: sck <= 1'b0;
        CONV: if (tick) bitcnt <= bitcnt + 6'd1;
        SHIFT: begin
          if (tick) sck <= ~sck;
          if (rise) begin
            bitcnt <= bitcnt + 6'd1;
            if (bitcnt >= 6'd2 && bitcnt <= 6'd15)
              s0 <= {s0[12:0], IN_SPI_MISO};
            if (bitcnt >= 6'd18 && bitcnt <= 6'd31)
              s1 <= {s1[12:0], IN_SPI_MISO};
          end
          if (fall && bitcnt == 6'd34) begin
            ch0   <= s0;
            ch1   <= s1;
            ready <= 1'b1;
          end
        end
`ifdef ADC_PREAMP_EN
        AMP_LOAD: begin
          if (tick) sck <= ~sck;
          if (rise) bitcnt <= bitcnt + 6'd1;
          if (fall) amp_sr <= {amp_sr[6:0], 1'b0};
        end
`endif
        default: ;
      endcase
      if (state_nxt != state) begin
        div    <= '0;
        bitcnt <= '0;
      end
    end
  end

  always_comb begin
    OUT_AD_CONV = (state == CONV);
    OUT_BUSY    = (state != IDLE);
`ifdef ADC_PREAMP_EN
    OUT_AMP_CS   = 1'b1;
    OUT_SPI_MOSI = 1'b0;
    OUT_AMP_SHDN = 1'b0;
    if (state == AMP_LOAD) begin
      OUT_AMP_CS   = 1'b0;
      OUT_SPI_MOSI = amp_sr[7];
    end
`endif
  end

  assign OUT_SPI_SCK      = sck;
  assign OUT_CH0          = ch0;
  assign OUT_CH1          = ch1;
  assign OUT_SAMPLE_READY = ready;
  assign OUT_STATE        = state;

endmodule
